// File: rtl/mux_nway_rr.sv
// mux_nway_rr: N-way valid/ready multiplexer with round-robin or fixed-priority
// arbitration, optional forced select, and a one-deep registered output stage.
module mux_nway_rr #(
  parameter int N = 8,
  parameter int W = 16,
  parameter int MODE = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N*W-1:0]  in_data_i,
  input  logic [N-1:0]    in_valid_i,
  output logic [N-1:0]    in_ready_o,
  input  logic            force_en_i,
  input  logic [SELW-1:0] force_sel_i,
  output logic [W-1:0]    out_data_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [SELW-1:0] out_sel_o,
  output logic [15:0]     xfer_count_o
);
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, g, ptr_next;
  logic            valid_q, valid_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [N-1:0]    elig;
  logic            any, load, grant;

  // First eligible index scanning upward from p (mod N); p is 0 in fixed-priority mode.
  function automatic logic [SELW-1:0] pick(input logic [N-1:0] e, input logic [SELW-1:0] p);
    logic            hit;
    logic [SELW-1:0] r;
    int              j;
    hit = 1'b0;
    r = '0;
    for (int i = 0; i < N; i++) begin
      j = (MODE == 0) ? (int'(p) + i) % N : i;
      if (!hit && e[j]) begin
        hit = 1'b1;
        r = SELW'(j);
      end
    end
    return r;
  endfunction

  always_comb begin
    elig = '0;
    for (int k = 0; k < N; k++)
      elig[k] = in_valid_i[k] && (!force_en_i || force_sel_i == SELW'(k));
    any = |elig;
    load = !valid_q || out_ready_i;
    grant = load && any;
    g = pick(elig, ptr_q);
    ptr_next = (int'(g) == N - 1) ? '0 : g + 1'b1;
    in_ready_o = grant ? (N'(1) << g) : '0;
    data_d = grant ? in_data_i[int'(g)*W +: W] : data_q;
    sel_d = grant ? g : sel_q;
    valid_d = load ? any : valid_q;
    ptr_d = (MODE == 0 && grant) ? ptr_next : ptr_q;
    cnt_d = cnt_q + 16'(valid_q && out_ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      sel_q <= '0;
      valid_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      sel_q <= sel_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_data_o = data_q;
  assign out_valid_o = valid_q;
  assign out_sel_o = sel_q;
  assign xfer_count_o = cnt_q;
endmodule
